// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and constants for the six-source bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  localparam int NUM_REQ = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Same encoding as the MUX6 select case items
  localparam logic [5:0] SEL0 = 6'b000001;
  localparam logic [5:0] SEL1 = 6'b000010;
  localparam logic [5:0] SEL2 = 6'b000100;
  localparam logic [5:0] SEL3 = 6'b001000;
  localparam logic [5:0] SEL4 = 6'b010000;
  localparam logic [5:0] SEL5 = 6'b100000;

  function automatic logic [2:0] next_ptr(input logic [2:0] id);
    return (id == 3'd5) ? 3'd0 : id + 3'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick6.sv
// ============================================================================
// Module      : rr_pick6
// Description : Combinational round-robin pick of one of six requests from ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick6
  import arb_pkg::*;
(
  input  logic [5:0] req,
  input  logic [2:0] ptr,
  output logic       win_valid,
  output logic [2:0] win_id,
  output logic [5:0] win_onehot
);

  logic [11:0] w_dbl;
  logic [5:0]  w_rot;
  logic [2:0]  w_off;
  logic [3:0]  w_sum;

  // Doubling the vector turns the rotate into a plain part-select
  assign w_dbl = {req, req};
  assign w_rot = w_dbl[ptr +: 6];

  always_comb begin
    w_off     = 3'd0;
    win_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off     = 3'(k);
        win_valid = 1'b1;
      end
    end
  end

  assign w_sum      = {1'b0, w_off} + {1'b0, ptr};
  assign win_id     = (w_sum >= 4'd6) ? 3'(w_sum - 4'd6) : w_sum[2:0];
  assign win_onehot = win_valid ? (SEL0 << win_id) : 6'b000000;

endmodule

`default_nettype wire

// File: rtl/mux6_bus_arbiter.sv
// ============================================================================
// Module      : mux6_bus_arbiter
// Description : Round-robin owner of the MUX6 select with turnaround and hold limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux6_bus_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] req,
  output logic [5:0] grant,
  output logic [2:0] grant_id,
  output logic       busy,
  output logic       timeout,
  output logic [2:0] timeout_id
);

  localparam logic [HOLD_W-1:0] C_HOLD_LIM = HOLD_W'(MAX_HOLD);

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_ptr, w_ptr_nxt;
  logic [HOLD_W-1:0] r_cnt, w_cnt_nxt;
  logic [5:0]        r_grant, w_grant_nxt;
  logic [2:0]        r_grant_id, w_grant_id_nxt;
  logic              r_busy;
  logic              r_timeout, w_timeout_nxt;
  logic [2:0]        r_timeout_id, w_timeout_id_nxt;

  logic              w_win_valid;
  logic [2:0]        w_win_id;
  logic [5:0]        w_win_onehot;
  logic              w_owner_req;
  logic              w_limit;

  rr_pick6 u_pick (
    .req        (req),
    .ptr        (r_ptr),
    .win_valid  (w_win_valid),
    .win_id     (w_win_id),
    .win_onehot (w_win_onehot)
  );

  assign w_owner_req = |(req & r_grant);
  assign w_limit     = (MAX_HOLD != 0) && (r_cnt == C_HOLD_LIM);

  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_cnt_nxt        = r_cnt;
    w_grant_nxt      = r_grant;
    w_grant_id_nxt   = r_grant_id;
    w_timeout_nxt    = 1'b0;
    w_timeout_id_nxt = r_timeout_id;
    case (r_state)
      IDLE: begin
        w_grant_nxt    = 6'b000000;
        w_grant_id_nxt = 3'd0;
        if (w_win_valid) begin
          w_grant_nxt    = w_win_onehot;
          w_grant_id_nxt = w_win_id;
          w_ptr_nxt      = next_ptr(w_win_id);
          w_cnt_nxt      = HOLD_W'(1);
          w_state_nxt    = OWN;
        end
      end
      OWN: begin
        // Release is checked first so it wins over a coincident limit hit
        if (!w_owner_req || w_limit) begin
          w_grant_nxt    = 6'b000000;
          w_grant_id_nxt = 3'd0;
          w_cnt_nxt      = '0;
          w_state_nxt    = GAP;
          if (w_owner_req) begin
            w_timeout_nxt    = 1'b1;
            w_timeout_id_nxt = r_grant_id;
          end
        end else begin
          w_cnt_nxt = r_cnt + HOLD_W'(1);
        end
      end
      GAP: begin
        w_grant_nxt    = 6'b000000;
        w_grant_id_nxt = 3'd0;
        w_state_nxt    = IDLE;
      end
      default: begin
        w_grant_nxt    = 6'b000000;
        w_grant_id_nxt = 3'd0;
        w_state_nxt    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ptr        <= 3'd0;
      r_cnt        <= '0;
      r_grant      <= 6'b000000;
      r_grant_id   <= 3'd0;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
      r_timeout_id <= 3'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_grant      <= w_grant_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_busy       <= |w_grant_nxt;
      r_timeout    <= w_timeout_nxt;
      r_timeout_id <= w_timeout_id_nxt;
    end
  end

  assign grant      = r_grant;
  assign grant_id   = r_grant_id;
  assign busy       = r_busy;
  assign timeout    = r_timeout;
  assign timeout_id = r_timeout_id;

endmodule

`default_nettype wire
